// File: rtl/icache_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
// Optional build macro used by the top level: ICACHE_PERF_EN.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL_REQ,
    ST_REFILL_DATA,
    ST_RESPOND
  } state_e;

  // Widest address the helpers handle; callers cast to and from it.
  localparam int MAX_ADDR_W = 64;
  typedef logic [MAX_ADDR_W-1:0] addr_t;

  // Number of byte-select bits inside one instruction word.
  function automatic int byte_w(input int word_w);
    return $clog2(word_w / 8);
  endfunction

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int word_w,
                               input int line_words, input int num_sets);
    return addr_w - byte_w(word_w) - off_w(line_words) - idx_w(num_sets);
  endfunction

  // Extract w bits of an address starting at bit lsb.
  function automatic addr_t addr_field(input addr_t a, input int lsb, input int w);
    addr_t mask;
    mask = (addr_t'(1) << w) - addr_t'(1);
    return (a >> lsb) & mask;
  endfunction

  // Clear the low_bits least significant bits (line alignment).
  function automatic addr_t line_base(input addr_t a, input int low_bits);
    return (a >> low_bits) << low_bits;
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Control FSM for icache_dm_refill: fetch handshake, word-serial refill
// toward memory, beat counter and deferred flush handling.
// Handshake: a fetch is accepted on a rising edge where cpu_req && cpu_ready;
// mem_req is held until the edge where mem_gnt is seen, after which each
// mem_rvalid cycle delivers one beat in ascending word order.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hit,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic              cpu_req,
  output state_e            state,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OFF_W-1:0]  beat_cnt,
  output logic              refill_we,
  output logic              refill_last,
  output logic              valid_clr
);

  localparam logic [OFF_W-1:0] LAST_BEAT = {OFF_W{1'b1}};

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [OFF_W-1:0]    cnt_q, cnt_d;
  logic                flush_pend_q, flush_pend_d;
  logic                lookup_hit;
  logic                accept;

  // Next-state logic, handshake decode and flush/valid-clear decision.
  always_comb begin
    lookup_hit   = (state_q == ST_LOOKUP) && hit;
    cpu_ready    = (state_q == ST_IDLE) || lookup_hit;
    accept       = cpu_req && cpu_ready;
    refill_we    = (state_q == ST_REFILL_DATA) && mem_rvalid;
    refill_last  = refill_we && (cnt_q == LAST_BEAT);
    // Immediate flush when no refill is in flight; otherwise the pending
    // flush lands on the edge that writes the last beat (clear beats set).
    valid_clr    = (flush && ((state_q == ST_IDLE) || lookup_hit || (state_q == ST_RESPOND)))
                 || (refill_last && (flush_pend_q || flush));
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit) begin
          state_d = accept ? ST_LOOKUP : ST_IDLE;
        end else begin
          state_d      = ST_REFILL_REQ;
          mem_req_d    = 1'b1;
          mem_addr_d   = line_addr;
          flush_pend_d = flush;
        end
      end
      ST_REFILL_REQ: begin
        flush_pend_d = flush_pend_q || flush;
        if (mem_gnt) begin
          state_d   = ST_REFILL_DATA;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end
      end
      ST_REFILL_DATA: begin
        flush_pend_d = flush_pend_q || flush;
        if (mem_rvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d      = ST_RESPOND;
            flush_pend_d = 1'b0;
          end
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered memory-side outputs; reset abandons any refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign state    = state_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign beat_cnt = cnt_q;

endmodule

// File: rtl/icache_dm_refill.sv
// Parametrised direct-mapped instruction cache with valid/ready fetch
// handshake, word-serial refill and flush. Holds the tag/data/valid arrays,
// the hit compare and the read mux; control lives in icache_refill_fsm.
// Optional macro ICACHE_PERF_EN adds saturating hit_cnt/miss_cnt outputs.
module icache_dm_refill
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int NUM_SETS   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int B_W   = byte_w(WORD_W);
  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(NUM_SETS);
  localparam int TAG_W = tag_w(ADDR_W, WORD_W, LINE_WORDS, NUM_SETS);

  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  addr_t               req_addr_x;
  logic [OFF_W-1:0]    req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [ADDR_W-1:0]   line_addr;

  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [WORD_W-1:0]   data_q [NUM_SETS][LINE_WORDS];
  logic [NUM_SETS-1:0] valid_q, valid_d;

  state_e              fsm_state;
  logic                hit;
  logic [OFF_W-1:0]    beat_cnt;
  logic                refill_we;
  logic                refill_last;
  logic                valid_clr;

  // Split the registered request address into offset, index and tag.
  always_comb begin
    req_addr_x = addr_t'(req_addr_q);
    req_off    = OFF_W'(addr_field(req_addr_x, B_W, OFF_W));
    req_idx    = IDX_W'(addr_field(req_addr_x, B_W + OFF_W, IDX_W));
    req_tag    = TAG_W'(addr_field(req_addr_x, B_W + OFF_W + IDX_W, TAG_W));
    line_addr  = ADDR_W'(line_base(req_addr_x, B_W + OFF_W));
    hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  end

  icache_refill_fsm #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .hit         (hit),
    .line_addr   (line_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .cpu_req     (cpu_req),
    .state       (fsm_state),
    .cpu_ready   (cpu_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .beat_cnt    (beat_cnt),
    .refill_we   (refill_we),
    .refill_last (refill_last),
    .valid_clr   (valid_clr)
  );

  // Capture the address of each accepted fetch; set valid on the last beat,
  // with any flush taking precedence.
  always_comb begin
    req_addr_d = (cpu_req && cpu_ready) ? cpu_addr : req_addr_q;
    valid_d    = valid_q;
    if (refill_last) valid_d[req_idx] = 1'b1;
    if (valid_clr)   valid_d = '0;
  end

  // Valid bits and request address are the only reset state in the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q <= '0;
      valid_q    <= '0;
    end else begin
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
    end
  end

  // Refill beats fill the indexed line in order; the tag lands with the last beat.
  always_ff @(posedge clk) begin
    if (refill_we) data_q[req_idx][beat_cnt] <= mem_rdata;
    if (refill_last) tag_q[req_idx] <= req_tag;
  end

  // Response: a hit in LOOKUP, or the freshly written line in RESPOND.
  always_comb begin
    cpu_rvalid = ((fsm_state == ST_LOOKUP) && hit) || (fsm_state == ST_RESPOND);
    cpu_rdata  = cpu_rvalid ? data_q[req_idx][req_off] : '0;
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating lookup outcome counters; flush leaves them alone.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((fsm_state == ST_LOOKUP) && hit && (hit_cnt_q != 32'hFFFF_FFFF))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if ((fsm_state == ST_LOOKUP) && !hit && (miss_cnt_q != 32'hFFFF_FFFF))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  // Default build: no performance counters or their ports.
`endif

endmodule

// File: tb/tb_icache_dm_refill.sv
// Directed self-checking bench for icache_dm_refill (default geometry:
// 32-bit addresses/words, 8-word lines, 4 sets -> idx = addr[6:5], off = addr[4:2]).
module tb_icache_dm_refill;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 8;
  localparam int NUM_SETS   = 4;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b0;
  logic              flush      = 1'b0;
  logic              cpu_req    = 1'b0;
  logic [ADDR_W-1:0] cpu_addr   = '0;
  logic              cpu_ready;
  logic              cpu_rvalid;
  logic [WORD_W-1:0] cpu_rdata;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt    = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [WORD_W-1:0] mem_rdata  = '0;
`ifdef ICACHE_PERF_EN
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Refill results reported by the memory driver.
  bit                seen;
  logic [ADDR_W-1:0] addr_seen;
  int                held;
  int                early;

  icache_dm_refill #(
    .ADDR_W     (ADDR_W),
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS),
    .NUM_SETS   (NUM_SETS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ready  (cpu_ready),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // Driver: present one fetch for one cycle; returns at the LOOKUP negedge.
  task automatic issue(input logic [ADDR_W-1:0] a);
    cpu_req  = 1'b1;
    cpu_addr = a;
    @(negedge clk);
    cpu_req  = 1'b0;
  endtask

  // Driver: memory model. Waits (bounded) for mem_req, stalls the grant,
  // then sends LINE_WORDS beats base+i with gap idle cycles before each.
  // Returns at the negedge after the last beat (RESPOND when all went well).
  task automatic serve_refill(input logic [WORD_W-1:0] base, input int gnt_delay,
                              input int gap, input int flush_beat);
    seen = 1'b0; addr_seen = '0; held = 0; early = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_req === 1'b1) begin
        seen = 1'b1;
        addr_seen = mem_addr;
      end else begin
        if (cpu_rvalid === 1'b1) early++;
        @(negedge clk);
      end
    end
    // Junk beats while waiting for the grant must be ignored.
    for (int d = 0; d < gnt_delay; d++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      if (mem_req === 1'b1) held++;
      if (cpu_rvalid === 1'b1) early++;
    end
    mem_rvalid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int b = 0; b < LINE_WORDS; b++) begin
      for (int g = 0; g < gap; g++) begin
        if (cpu_rvalid === 1'b1) early++;
        @(negedge clk);
      end
      if (cpu_rvalid === 1'b1) early++;
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(b);
      flush      = (b == flush_beat);
      @(negedge clk);
      mem_rvalid = 1'b0;
      flush      = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", cpu_ready); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b want 0", cpu_rvalid); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %0b want 1", cpu_ready); end
`ifdef ICACHE_PERF_EN
    checks++; if (hit_cnt !== 32'h0) begin errors++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt); end
    checks++; if (miss_cnt !== 32'h0) begin errors++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
`endif
  endtask

  task automatic test_miss_refill();
    issue(32'h40);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL miss_lookup_rvalid: got %0b want 0", cpu_rvalid); end
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL miss_lookup_ready: got %0b want 0", cpu_ready); end
    serve_refill(32'h100, 0, 0, -1);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL miss_mem_req: mem_req never seen, want 1"); end
    checks++; if (addr_seen !== 32'h40) begin errors++; $display("FAIL miss_mem_addr: got %h want 00000040", addr_seen); end
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL miss_resp_rvalid: got %0b want 1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'h100) begin errors++; $display("FAIL miss_resp_rdata: got %h want 00000100", cpu_rdata); end
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL miss_resp_ready: got %0b want 0", cpu_ready); end
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL miss_one_pulse: got %0b want 0", cpu_rvalid); end
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL miss_back_idle: ready got %0b want 1", cpu_ready); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [3];
    logic [WORD_W-1:0] words [3];
    addrs = '{32'h44, 32'h48, 32'h5C};
    words = '{32'h101, 32'h102, 32'h107};
    cpu_req  = 1'b1;
    cpu_addr = addrs[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %0b want 1", i, cpu_rvalid); end
      checks++; if (cpu_rdata !== words[i]) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, cpu_rdata, words[i]); end
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %0b want 1", i, cpu_ready); end
      if (i < 2) cpu_addr = addrs[i+1];
      else cpu_req = 1'b0;
    end
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end_rvalid: got %0b want 0", cpu_rvalid); end
  endtask

  task automatic test_conflict();
    issue(32'h40);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h100) begin errors++; $display("FAIL conflict_first_hit: got v=%0b d=%h want v=1 d=00000100", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
    issue(32'hC0);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL conflict_c0_miss: rvalid got %0b want 0", cpu_rvalid); end
    serve_refill(32'h200, 0, 0, -1);
    checks++; if (addr_seen !== 32'hC0) begin errors++; $display("FAIL conflict_c0_addr: got %h want 000000c0", addr_seen); end
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h200) begin errors++; $display("FAIL conflict_c0_data: got v=%0b d=%h want v=1 d=00000200", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
    issue(32'h44);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL conflict_40_remiss: rvalid got %0b want 0", cpu_rvalid); end
    serve_refill(32'h100, 0, 0, -1);
    checks++; if (addr_seen !== 32'h40) begin errors++; $display("FAIL conflict_40_addr: got %h want 00000040", addr_seen); end
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h101) begin errors++; $display("FAIL conflict_40_data: got v=%0b d=%h want v=1 d=00000101", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_mem_stall();
    issue(32'h64);
    serve_refill(32'h300, 5, 2, -1);
    checks++; if (addr_seen !== 32'h60) begin errors++; $display("FAIL stall_addr: got %h want 00000060", addr_seen); end
    checks++; if (held !== 5) begin errors++; $display("FAIL stall_req_held: got %0d cycles want 5", held); end
    checks++; if (early !== 0) begin errors++; $display("FAIL stall_early_rvalid: got %0d want 0", early); end
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h301) begin errors++; $display("FAIL stall_data: got v=%0b d=%h want v=1 d=00000301", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
    issue(32'h7C);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h307) begin errors++; $display("FAIL stall_hit_last: got v=%0b d=%h want v=1 d=00000307", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    // Flush while idle invalidates both resident lines.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    issue(32'h40);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL flush_idle_miss: rvalid got %0b want 0", cpu_rvalid); end
    serve_refill(32'h500, 0, 1, 3);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h500) begin errors++; $display("FAIL flush_refill_word: got v=%0b d=%h want v=1 d=00000500", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
    issue(32'h40);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL flush_pend_miss: rvalid got %0b want 0", cpu_rvalid); end
    serve_refill(32'h600, 0, 0, -1);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h600) begin errors++; $display("FAIL flush_refill2: got v=%0b d=%h want v=1 d=00000600", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
    issue(32'h64);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL flush_set3_miss: rvalid got %0b want 0", cpu_rvalid); end
    serve_refill(32'h300, 0, 0, -1);
    @(negedge clk);
    // Flush coincident with a hit still returns the hit word.
    issue(32'h48);
    flush = 1'b1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h602) begin errors++; $display("FAIL flush_on_hit: got v=%0b d=%h want v=1 d=00000602", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
    flush = 1'b0;
    issue(32'h48);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL flush_on_hit_after: rvalid got %0b want 0", cpu_rvalid); end
    serve_refill(32'h800, 0, 0, -1);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h802) begin errors++; $display("FAIL flush_on_hit_refill: got v=%0b d=%h want v=1 d=00000802", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_refill();
    bit got_req;
    issue(32'hC0);
    got_req = 1'b0;
    for (int i = 0; i < 20 && !got_req; i++) begin
      if (mem_req === 1'b1) got_req = 1'b1;
      else @(negedge clk);
    end
    checks++; if (got_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req: mem_req never seen, want 1"); end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h900 + 32'(b);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    // Assert reset between clock edges; outputs must react without a clock.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_async_mem_req: got %0b want 0", mem_req); end
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %0b want 1", cpu_ready); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_async_rvalid: got %0b want 0", cpu_rvalid); end
`ifdef ICACHE_PERF_EN
    checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin errors++; $display("FAIL rst_async_perf: got hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'h48);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_after_miss: rvalid got %0b want 0", cpu_rvalid); end
    serve_refill(32'h700, 0, 0, -1);
    checks++; if (addr_seen !== 32'h40) begin errors++; $display("FAIL rst_after_addr: got %h want 00000040", addr_seen); end
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h702) begin errors++; $display("FAIL rst_after_data: got v=%0b d=%h want v=1 d=00000702", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_back_to_back();
    test_conflict();
    test_mem_stall();
    test_flush();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_dm_refill.md
Name: icache_dm_refill

Overview:
- Parametrised direct-mapped instruction cache; the next generation of the single-cycle fetch cache.
- Sits between the fetch stage and instruction memory.
- Adds a valid/ready fetch handshake, a word-serial refill FSM toward memory, reset, and a flush input.
- Geometry (sets, line size, widths) is set by parameters instead of fixed 4 sets x 256-bit lines.

Parameters:
ADDR_W, 32, fetch/memory address width (byte address)
WORD_W, 32, instruction word width; power of two, >= 8
LINE_WORDS, 8, words per line; power of two, >= 2
NUM_SETS, 4, number of lines; power of two, >= 2

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  invalidate all lines (pulse or level)
cpu_req  in  1  fetch request valid
cpu_addr  in  ADDR_W  fetch byte address
cpu_ready  out  1  cache can accept a request this cycle
cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse per request
cpu_rdata  out  WORD_W  fetched instruction word
mem_req  out  1  refill request, held until mem_gnt
mem_addr  out  ADDR_W  line-aligned refill address (offset bits zero)
mem_gnt  in  1  memory accepted mem_req
mem_rvalid  in  1  one refill beat on mem_rdata
mem_rdata  in  WORD_W  refill word; beats arrive in ascending word order

Behaviour:
- Address split, with B = log2(WORD_W/8):
  - byte bits [B-1:0] ignored
  - word offset: next log2(LINE_WORDS) bits
  - index: next log2(NUM_SETS) bits
  - tag: the remaining upper bits
- Arrays: tag[NUM_SETS], data[NUM_SETS][LINE_WORDS], valid[NUM_SETS].
  - Reset clears every valid bit and nothing else.
- Reset values: cpu_ready=1, cpu_rvalid=0, cpu_rdata=0, mem_req=0, mem_addr=0, FSM=IDLE, beat counter=0.
- Accept: cpu_req && cpu_ready. The address is registered into req_addr and LOOKUP occurs in the next cycle.
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESPOND.
  - IDLE: cpu_ready=1. On accept -> LOOKUP.
  - LOOKUP: hit = valid[idx] && tag[idx]==req_tag.
    - Hit: cpu_rvalid=1, cpu_rdata=data[idx][off]. cpu_ready=1, so a new request can be accepted in the same cycle (back-to-back hits give 1 word/cycle, latency 1). Next state is LOOKUP if a new request was accepted, else IDLE.
    - Miss: cpu_ready=0 -> REFILL_REQ.
  - REFILL_REQ: mem_req=1, mem_addr=req_addr with offset and byte bits zeroed. mem_gnt -> REFILL_DATA, beat counter=0.
    - mem_rvalid is ignored in this state.
  - REFILL_DATA: mem_req=0. Each mem_rvalid writes data[idx][cnt] and increments cnt.
    - The beat with cnt==LINE_WORDS-1 writes tag[idx]=req_tag, sets valid[idx]=1, then -> RESPOND.
  - RESPOND: cpu_rvalid=1, cpu_rdata=data[idx][off] from the freshly written line; cpu_ready=0 -> IDLE.
- cpu_ready=0 in REFILL_REQ, REFILL_DATA and RESPOND. Exactly one cpu_rvalid per accepted request; responses return in order.
- Refill always overwrites the indexed line (direct mapped, no write path).
- flush:
  - In IDLE, or in LOOKUP with a hit: clears all valid bits at that edge.
    - A hit being reported in that same LOOKUP cycle is still returned.
    - A request accepted in the same cycle sees the flushed state.
  - In LOOKUP with a miss, REFILL_REQ or REFILL_DATA: latched as flush_pend. It is applied at entry to RESPOND, after the line is written. The current request still returns the refilled word; the line is then invalid.
- Asynchronous reset mid-refill: state abandoned, all valid bits cleared, mem_req drops immediately. Memory is expected to be reset by the same rst_n.
- The beat counter is log2(LINE_WORDS) bits wide and wraps only at the final beat.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- When defined, the block adds outputs hit_cnt (out, 32) and miss_cnt (out, 32).
  - Counts LOOKUP hits and misses.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
  - flush does not clear them.
- When undefined, neither the ports nor the counters exist; functional behaviour is identical.

Decomposition:
- Shared package icache_pkg:
  - FSM state enum (IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESPOND)
  - localparam helper functions for OFF_W, IDX_W, TAG_W derived from the parameters
  - address field-extraction functions
- One sub-module: icache_refill_fsm, which owns the FSM, beat counter, flush_pend and mem_* handshake. The top-level holds the arrays, hit compare and data mux.

Test Plan:
- Reset, then cpu_req addr 0x0000_0040 -> miss; mem_req with mem_addr 0x40; after gnt and 8 beats (0x100..0x107) cpu_rvalid returns 0x100.
- Back-to-back requests 0x44, 0x48, 0x5C after that refill -> rvalid on three consecutive cycles with 0x101, 0x102, 0x107; cpu_ready stays 1.
- Conflict: 0x40, then 0xC0 (same index, different tag) -> second request refills; re-request 0x40 -> miss again.
- Memory stalls: mem_gnt delayed 5 cycles and gaps between beats -> mem_req held, no early rvalid, correct word returned.
- flush during REFILL_DATA of 0x40 -> refilled word still returned; next 0x40 -> miss.
- rst_n low during REFILL_DATA -> mem_req=0, cpu_ready=1, cpu_rvalid=0 asynchronously; after release 0x40 -> miss. With ICACHE_PERF_EN, hit_cnt/miss_cnt=0 after reset.
